seq_serializer: RTL and testbench

- Parallel-in/serial-out stage directly upstream of the sequence detector.
- Accepts WIDTH-bit words through a valid/ready handshake and shifts them out MSB first, one bit per enabled clock.
- cout drives the detector's cin input; cout_valid qualifies each bit.
- Replaces the bench-style shift-register stimulus with synthesizable framing: back-to-back streaming, optional inter-word gap, bit-rate enable.

---
 rtl/seq_serializer.sv | 155 +++++++++++++++
 tb/tb_seq_serializer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-in / serial-out framing stage feeding the sequence
// detector's cin. Words are taken over a valid/ready handshake and shifted
// out MSB first, one bit per enabled clock, with optional inter-word gap.
// Optional feature macro: SERIALIZER_PARITY_EN appends an even-parity bit
// after the data bits of every frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a word; din_ready=1, no bit on cout
// S_SHIFT | frame in progress; cout carries the current bit
// S_GAP   | GAP enabled idle cycles between frames; din_ready=0
module seq_serializer #(
   parameter int WIDTH = 10,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             en,
   output logic             cout,
   output logic             cout_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW         = $clog2(WIDTH + 1);
   localparam int GW         = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
`ifdef SERIALIZER_PARITY_EN
   localparam int LAST_I     = WIDTH;
`else
   localparam int LAST_I     = WIDTH - 1;
`endif
   localparam logic [CW-1:0] LAST     = CW'(LAST_I);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic             last_bit;
`ifdef SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif

   // last bit of the frame is being consumed this cycle
   assign last_bit = (cnt_q == LAST) && en;

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
`ifdef SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
`ifdef SERIALIZER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // next-state, datapath update and output decode
   always_comb begin
      state_d    = state_q;
      sreg_d     = sreg_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
`ifdef SERIALIZER_PARITY_EN
      par_d      = par_q;
`endif
      din_ready  = 1'b0;
      cout       = 1'b0;
      cout_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_q)
         S_IDLE: begin
            din_ready = 1'b1;
            if (din_valid) begin
               sreg_d  = din;
               cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
               par_d   = ^din;
`endif
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            cout_valid = 1'b1;
            busy       = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            cout       = (cnt_q == CW'(WIDTH)) ? par_q : sreg_q[WIDTH-1];
`else
            cout       = sreg_q[WIDTH-1];
`endif
            // back-to-back reload is only possible when no gap follows
            din_ready  = last_bit && (GAP == 0);
            if (en) begin
               if (cnt_q == LAST) begin
                  done = 1'b1;
                  if (GAP > 0) begin
                     gap_d   = '0;
                     state_d = S_GAP;
                  end else if (din_valid) begin
                     sreg_d  = din;
                     cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
                     par_d   = ^din;
`endif
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                  cnt_d  = cnt_q + CW'(1);
               end
            end
         end

         S_GAP: begin
            busy = 1'b1;
            if (en) begin
               if (gap_q == GAP_LAST) begin
                  state_d = S_IDLE;
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: two instances (GAP=0 on channel 0, GAP=3 on
// channel 1). Stimulus pushes the expected bit stream per accepted word into
// a per-channel queue; a monitor pops and compares on every consumed bit.
module tb_seq_serializer;

   localparam int W    = 10;
   localparam int GAPB = 3;
`ifdef SERIALIZER_PARITY_EN
   localparam int NB   = W + 1;
`else
   localparam int NB   = W;
`endif

   typedef struct packed {
      logic b;
      logic d;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         en;
   logic [W-1:0] din_s [2];
   logic         dv    [2];
   logic         din_ready_a, cout_a, cout_valid_a, busy_a, done_a;
   logic         din_ready_b, cout_b, cout_valid_b, busy_b, done_b;
   logic [1:0]   rdy_w, cout_w, cv_w, busy_w, done_w;

   exp_t q [2][$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   vcnt = 0, vfirst = 0, vlast = 0;
   int   gcnt = 0, gviol = 0;

   seq_serializer #(.WIDTH(W), .GAP(0)) u_a (
      .clk(clk), .rst(rst), .din(din_s[0]), .din_valid(dv[0]),
      .din_ready(din_ready_a), .en(en), .cout(cout_a),
      .cout_valid(cout_valid_a), .busy(busy_a), .done(done_a)
   );

   seq_serializer #(.WIDTH(W), .GAP(GAPB)) u_b (
      .clk(clk), .rst(rst), .din(din_s[1]), .din_valid(dv[1]),
      .din_ready(din_ready_b), .en(en), .cout(cout_b),
      .cout_valid(cout_valid_b), .busy(busy_b), .done(done_b)
   );

   assign rdy_w  = {din_ready_b, din_ready_a};
   assign cout_w = {cout_b, cout_a};
   assign cv_w   = {cout_valid_b, cout_valid_a};
   assign busy_w = {busy_b, busy_a};
   assign done_w = {done_b, done_a};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // present a word on channel ch, push its expected bits, return 1ns after the accept edge
   task automatic send(input int ch, input logic [W-1:0] w, input logic par, input bit hold);
      exp_t e;
      bit   ok;
      din_s[ch] = w;
      dv[ch]    = 1'b1;
      ok        = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         if (rdy_w[ch]) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk($sformatf("ch%0d accept", ch), {31'd0, ok}, 32'd1);
      if (ok) begin
         for (int i = W - 1; i >= 0; i--) begin
            e.b = w[i];
`ifdef SERIALIZER_PARITY_EN
            e.d = 1'b0;
`else
            e.d = (i == 0);
`endif
            q[ch].push_back(e);
         end
`ifdef SERIALIZER_PARITY_EN
         e.b = par;
         e.d = 1'b1;
         q[ch].push_back(e);
`else
         if (par === 1'bx) $display("note: parity unknown");
`endif
         @(posedge clk);
         #1;
      end
      if (!hold) dv[ch] = 1'b0;
   endtask

   task automatic wait_idle(input int ch);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (!busy_w[ch] && !cv_w[ch] && q[ch].size() == 0) ok = 1'b1;
      end
      chk($sformatf("ch%0d frame completion", ch), {31'd0, ok}, 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " cout"},       {31'd0, cout_a},       32'd0);
      chk({tag, " cout_valid"}, {31'd0, cout_valid_a}, 32'd0);
      chk({tag, " busy"},       {31'd0, busy_a},       32'd0);
      chk({tag, " done"},       {31'd0, done_a},       32'd0);
      chk({tag, " din_ready"},  {31'd0, din_ready_a},  32'd1);
      chk({tag, " b din_ready"}, {31'd0, din_ready_b}, 32'd1);
   endtask

   // scoreboard monitor: compare each presented bit, pop when it is consumed
   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < 2; c++) begin
            if (cv_w[c]) begin
               if (q[c].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL ch%0d unexpected bit: got %b expected none", c, cout_w[c]);
               end else begin
                  checks++;
                  if (cout_w[c] !== q[c][0].b) begin
                     errors++;
                     $display("FAIL ch%0d bit: got %b expected %b (cycle %0d)", c, cout_w[c], q[c][0].b, cyc);
                  end
                  checks++;
                  if (en) begin
                     if (done_w[c] !== q[c][0].d) begin
                        errors++;
                        $display("FAIL ch%0d done: got %b expected %b (cycle %0d)", c, done_w[c], q[c][0].d, cyc);
                     end
                     void'(q[c].pop_front());
                  end else if (done_w[c] !== 1'b0 || rdy_w[c] !== 1'b0) begin
                     errors++;
                     $display("FAIL ch%0d hold: got done=%b ready=%b expected 0/0", c, done_w[c], rdy_w[c]);
                  end
               end
            end else if (done_w[c] !== 1'b0) begin
               checks++;
               errors++;
               $display("FAIL ch%0d stray done: got 1 expected 0 (cycle %0d)", c, cyc);
            end
         end
         if (cout_valid_a) begin
            if (vcnt == 0) vfirst = cyc;
            vlast = cyc;
            vcnt++;
         end
         if (busy_b && !cout_valid_b) begin
            gcnt++;
            if (din_ready_b) gviol++;
         end
      end
   end

   initial begin
      int dcyc;
      int rviol;
      rst      = 1'b1;
      en       = 1'b1;
      din_s[0] = '0;
      din_s[1] = '0;
      dv[0]    = 1'b0;
      dv[1]    = 1'b0;

      #2;
      chk_reset_outputs("reset held");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("after release");

      // single words, en=1
      @(posedge clk);
      #1;
      send(0, 10'b1101011010, 1'b0, 1'b0);
      wait_idle(0);
      @(posedge clk);
      #1;
      send(0, 10'b0000000111, 1'b1, 1'b0);
      wait_idle(0);

      // enable throttling: en low on odd cycles after accept
      @(posedge clk);
      #1;
      send(0, 10'b1101011010, 1'b0, 1'b0);
      dcyc  = 0;
      rviol = 0;
      for (int k = 1; k <= 2 * NB + 2; k++) begin
         en = (k % 2 == 0);
         @(negedge clk);
         if (done_a && dcyc == 0) dcyc = k;
         if (k < 2 * NB && din_ready_a) rviol++;
         @(posedge clk);
         #1;
      end
      en = 1'b1;
      chk("throttle done cycle", dcyc, 2 * NB);
      chk("throttle ready low", rviol, 0);
      wait_idle(0);

      // back-to-back streaming
      @(posedge clk);
      #1;
      vcnt = 0;
      send(0, 10'h3FF, 1'b0, 1'b1);
      send(0, 10'h000, 1'b0, 1'b0);
      wait_idle(0);
      chk("b2b valid bits", vcnt, 2 * NB);
      chk("b2b contiguous", vlast - vfirst + 1, 2 * NB);

      // mid-frame reset after bit 5
      @(posedge clk);
      #1;
      send(0, 10'b1101011010, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk_reset_outputs("async reset");
      q[0].delete();
      @(posedge clk);
      #1 rst = 1'b0;
      send(0, 10'b1000000001, 1'b0, 1'b0);
      wait_idle(0);

      // gap insertion on the GAP=3 instance
      @(posedge clk);
      #1;
      gcnt  = 0;
      gviol = 0;
      send(1, 10'h3FF, 1'b0, 1'b1);
      send(1, 10'h000, 1'b0, 1'b0);
      chk("gap cycles between frames", gcnt, GAPB);
      wait_idle(1);
      chk("gap cycles total", gcnt, 2 * GAPB);
      chk("gap ready low", gviol, 0);
      chk("b idle busy", {31'd0, busy_b}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
